// File: rtl/caliptra_prim_shared_reg_arb_pkg.sv
// Shared types and helpers for the shared-register arbiter.
// Holds the FSM state encoding and the index-width helper used by its ports.
package caliptra_prim_shared_reg_arb_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } arb_state_e;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/caliptra_prim_generic_flop.sv
// Plain register with asynchronous active-low reset to a parameterised value.
module caliptra_prim_generic_flop #(
    parameter int unsigned      Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= ResetValue;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/caliptra_prim_shared_reg_arb.sv
// Round-robin arbitrated shared register with an optional owner lock that is
// force-released after LockTimeout idle cycles.
module caliptra_prim_shared_reg_arb
    import caliptra_prim_shared_reg_arb_pkg::*;
#(
    parameter int unsigned      NumReq      = 4,
    parameter int unsigned      Width       = 32,
    parameter logic [Width-1:0] ResetValue  = '0,
    parameter int unsigned      LockTimeout = 16,
    localparam int unsigned     IdxW        = idx_width(NumReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumReq-1:0]            req_i,
    input  logic [NumReq-1:0]            lock_i,
    input  logic [NumReq-1:0][Width-1:0] wdata_i,
    output logic [NumReq-1:0]            gnt_o,
    output logic [Width-1:0]             q_o,
    output logic                         wr_o,
    output logic [IdxW-1:0]              owner_o,
    output logic                         locked_o,
    output logic                         lock_timeout_o
);

    localparam int unsigned     CntW   = $clog2(LockTimeout);
    localparam logic [CntW-1:0] CntMax = CntW'(LockTimeout - 1);

    arb_state_e        state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              timeout_q, timeout_d;

    logic [NumReq-1:0] arb_gnt;
    logic [IdxW-1:0]   arb_idx;
    logic              arb_found;
    logic [IdxW-1:0]   wr_idx;
    logic              wr_en;
    logic [Width-1:0]  q_d;

    function automatic logic [IdxW-1:0] next_idx(logic [IdxW-1:0] idx);
        return (idx == IdxW'(NumReq - 1)) ? '0 : idx + IdxW'(1);
    endfunction

    // Rotating priority search starting at rr_ptr_q.
    always_comb begin
        logic [IdxW-1:0] cand;
        arb_gnt   = '0;
        arb_idx   = '0;
        arb_found = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = IdxW'((32'(rr_ptr_q) + i) % NumReq);
            if (!arb_found && req_i[cand]) begin
                arb_found     = 1'b1;
                arb_idx       = cand;
                arb_gnt[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            wr_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        wr_d      = wr_en;
        timeout_d = 1'b0;
        if (wr_en) begin
            owner_d = wr_idx;
        end
        case (state_q)
            StIdle: begin
                if (wr_en) begin
                    rr_ptr_d = next_idx(arb_idx);
                    if (lock_i[arb_idx]) begin
                        state_d = StLocked;
                        cnt_d   = '0;
                    end
                end
            end
            StLocked: begin
                // An owner write on the final count wins over the timeout.
                if (wr_en) begin
                    cnt_d = '0;
                    if (!lock_i[owner_q]) begin
                        state_d  = StIdle;
                        rr_ptr_d = next_idx(owner_q);
                    end
                end else if (cnt_q == CntMax) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_idx(owner_q);
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        gnt_o  = '0;
        wr_idx = arb_idx;
        case (state_q)
            StIdle: begin
                gnt_o = arb_gnt;
            end
            StLocked: begin
                gnt_o[owner_q] = req_i[owner_q];
                wr_idx         = owner_q;
            end
            default: begin
                gnt_o = '0;
            end
        endcase
        wr_en = |gnt_o;
    end

    assign q_d            = wr_en ? wdata_i[wr_idx] : q_o;
    assign wr_o           = wr_q;
    assign owner_o        = owner_q;
    assign locked_o       = (state_q == StLocked);
    assign lock_timeout_o = timeout_q;

    caliptra_prim_generic_flop #(
        .Width      (Width),
        .ResetValue (ResetValue)
    ) u_q_flop (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (q_d),
        .q_o    (q_o)
    );

    gnt_onehot_a : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

    for (genvar i = 0; i < NumReq; i++) begin : g_req_hold
        req_hold_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (req_i[i] && !gnt_o[i]) |=> (req_i[i] && $stable(wdata_i[i])));
    end

endmodule

// File: tb/tb_caliptra_prim_shared_reg_arb.sv
// Directed self-checking bench for the shared-register arbiter at default parameters.
module tb_caliptra_prim_shared_reg_arb;

    logic            clk_i;
    logic            rst_ni;
    logic [3:0]      req_i;
    logic [3:0]      lock_i;
    logic [3:0][31:0] wdata_i;
    logic [3:0]      gnt_o;
    logic [31:0]     q_o;
    logic            wr_o;
    logic [1:0]      owner_o;
    logic            locked_o;
    logic            lock_timeout_o;

    int vec_cnt;
    int err_cnt;

    caliptra_prim_shared_reg_arb dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .lock_i         (lock_i),
        .wdata_i        (wdata_i),
        .gnt_o          (gnt_o),
        .q_o            (q_o),
        .wr_o           (wr_o),
        .owner_o        (owner_o),
        .locked_o       (locked_o),
        .lock_timeout_o (lock_timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #2;
        req_i   = '0;
        lock_i  = '0;
        wdata_i = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if (q_o !== 32'h0) begin
            err_cnt++; $display("FAIL reset_q got %h exp %h", q_o, 32'h0);
        end
        vec_cnt++;
        if ({wr_o, locked_o, lock_timeout_o} !== 3'b000) begin
            err_cnt++; $display("FAIL reset_flags got %b exp 000", {wr_o, locked_o, lock_timeout_o});
        end
        vec_cnt++;
        if (owner_o !== 2'd0) begin
            err_cnt++; $display("FAIL reset_owner got %0d exp 0", owner_o);
        end
        vec_cnt++;
        if (gnt_o !== 4'b0000) begin
            err_cnt++; $display("FAIL reset_gnt got %b exp 0000", gnt_o);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) wdata_i[i] = 32'hA0 + 32'(i);
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            #1;
            vec_cnt++;
            if (gnt_o !== 4'(1 << e)) begin
                err_cnt++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt_o, 4'(1 << e));
            end
            step();
            vec_cnt++;
            if (q_o !== 32'hA0 + 32'(e) || wr_o !== 1'b1 || owner_o !== 2'(e)) begin
                err_cnt++;
                $display("FAIL rr_write[%0d] got q=%h wr=%b own=%0d exp q=%h wr=1 own=%0d",
                         k, q_o, wr_o, owner_o, 32'hA0 + 32'(e), e);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wdata_i[2] = 32'h22; wdata_i[3] = 32'h33; wdata_i[0] = 32'h30;
        req_i = 4'b0100;
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b0100) begin
            err_cnt++; $display("FAIL wrap_g2 got %b exp 0100", gnt_o);
        end
        step();
        req_i = 4'b1001;
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b1000) begin
            err_cnt++; $display("FAIL wrap_g3 got %b exp 1000", gnt_o);
        end
        step();
        vec_cnt++;
        if (q_o !== 32'h33) begin
            err_cnt++; $display("FAIL wrap_q3 got %h exp 33", q_o);
        end
        req_i = 4'b0001;
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b0001) begin
            err_cnt++; $display("FAIL wrap_g0 got %b exp 0001", gnt_o);
        end
        step();
        req_i = 4'b0000;
        vec_cnt++;
        if (q_o !== 32'h30 || owner_o !== 2'd0) begin
            err_cnt++; $display("FAIL wrap_q0 got q=%h own=%0d exp q=30 own=0", q_o, owner_o);
        end
        step();
        vec_cnt++;
        if (wr_o !== 1'b0 || q_o !== 32'h30 || owner_o !== 2'd0) begin
            err_cnt++;
            $display("FAIL idle_hold got wr=%b q=%h own=%0d exp wr=0 q=30 own=0", wr_o, q_o, owner_o);
        end
    endtask

    task automatic test_lock_release();
        do_reset();
        wdata_i[1] = 32'h55; wdata_i[2] = 32'h77;
        req_i = 4'b0110; lock_i = 4'b0010;
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b0010) begin
            err_cnt++; $display("FAIL lock_g1 got %b exp 0010", gnt_o);
        end
        step();
        req_i = 4'b0100; lock_i = 4'b0000;
        vec_cnt++;
        if (locked_o !== 1'b1 || q_o !== 32'h55 || owner_o !== 2'd1) begin
            err_cnt++;
            $display("FAIL lock_enter got lk=%b q=%h own=%0d exp lk=1 q=55 own=1", locked_o, q_o, owner_o);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            vec_cnt++;
            if (gnt_o !== 4'b0000 || locked_o !== 1'b1) begin
                err_cnt++; $display("FAIL lock_stall[%0d] got gnt=%b lk=%b exp gnt=0000 lk=1", c, gnt_o, locked_o);
            end
            step();
        end
        wdata_i[1] = 32'h66; req_i = 4'b0110;
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b0010) begin
            err_cnt++; $display("FAIL lock_owner_g got %b exp 0010", gnt_o);
        end
        step();
        req_i = 4'b0100;
        vec_cnt++;
        if (locked_o !== 1'b0 || q_o !== 32'h66 || wr_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL lock_release got lk=%b q=%h wr=%b exp lk=0 q=66 wr=1", locked_o, q_o, wr_o);
        end
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b0100) begin
            err_cnt++; $display("FAIL lock_next_g2 got %b exp 0100", gnt_o);
        end
        step();
        req_i = 4'b0000;
        vec_cnt++;
        if (q_o !== 32'h77 || owner_o !== 2'd2) begin
            err_cnt++; $display("FAIL lock_q2 got q=%h own=%0d exp q=77 own=2", q_o, owner_o);
        end
    endtask

    task automatic test_timeout();
        int pulses;
        do_reset();
        wdata_i[0] = 32'h11; req_i = 4'b0001; lock_i = 4'b0001;
        step();
        req_i = 4'b0000; lock_i = 4'b0000;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            if (lock_timeout_o === 1'b1) pulses++;
            vec_cnt++;
            if (locked_o !== 1'b1) begin
                err_cnt++; $display("FAIL to_hold[%0d] got lk=%b exp 1", c, locked_o);
            end
            step();
        end
        vec_cnt++;
        if (locked_o !== 1'b0 || lock_timeout_o !== 1'b1 || q_o !== 32'h11) begin
            err_cnt++;
            $display("FAIL to_fire got lk=%b to=%b q=%h exp lk=0 to=1 q=11", locked_o, lock_timeout_o, q_o);
        end
        step();
        vec_cnt++;
        if (lock_timeout_o !== 1'b0 || pulses !== 0) begin
            err_cnt++; $display("FAIL to_once got to=%b early=%0d exp to=0 early=0", lock_timeout_o, pulses);
        end
        wdata_i[1] = 32'h12; req_i = 4'b0011;
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b0010) begin
            err_cnt++; $display("FAIL to_rrptr got %b exp 0010", gnt_o);
        end
        step();
        req_i = 4'b0001;
        step();
        req_i = 4'b0000;
    endtask

    task automatic test_final_cycle_write();
        do_reset();
        wdata_i[0] = 32'h11; req_i = 4'b0001; lock_i = 4'b0001;
        step();
        req_i = 4'b0000; lock_i = 4'b0000;
        repeat (15) step();
        wdata_i[0] = 32'h22; req_i = 4'b0001;
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b0001) begin
            err_cnt++; $display("FAIL fin_gnt got %b exp 0001", gnt_o);
        end
        step();
        req_i = 4'b0000;
        vec_cnt++;
        if (lock_timeout_o !== 1'b0 || q_o !== 32'h22 || locked_o !== 1'b0 || wr_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL fin_write got to=%b q=%h lk=%b wr=%b exp to=0 q=22 lk=0 wr=1",
                     lock_timeout_o, q_o, locked_o, wr_o);
        end
        step();
        vec_cnt++;
        if (lock_timeout_o !== 1'b0) begin
            err_cnt++; $display("FAIL fin_no_to got %b exp 0", lock_timeout_o);
        end
    endtask

    task automatic test_reset_in_lock();
        do_reset();
        wdata_i[2] = 32'h1234; req_i = 4'b0100; lock_i = 4'b0100;
        step();
        req_i = 4'b0000; lock_i = 4'b0000;
        vec_cnt++;
        if (locked_o !== 1'b1 || q_o !== 32'h1234) begin
            err_cnt++; $display("FAIL rl_pre got lk=%b q=%h exp lk=1 q=1234", locked_o, q_o);
        end
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        vec_cnt++;
        if (q_o !== 32'h0 || locked_o !== 1'b0 || lock_timeout_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL rl_async got q=%h lk=%b to=%b exp q=0 lk=0 to=0", q_o, locked_o, lock_timeout_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step();
        vec_cnt++;
        if (lock_timeout_o !== 1'b0 || locked_o !== 1'b0) begin
            err_cnt++; $display("FAIL rl_post got to=%b lk=%b exp 0 0", lock_timeout_o, locked_o);
        end
        wdata_i[1] = 32'hB1; wdata_i[2] = 32'hB2; req_i = 4'b0110;
        #1;
        vec_cnt++;
        if (gnt_o !== 4'b0010) begin
            err_cnt++; $display("FAIL rl_first_g got %b exp 0010", gnt_o);
        end
        step();
        req_i = 4'b0100;
        step();
        req_i = 4'b0000;
        vec_cnt++;
        if (q_o !== 32'hB2 || owner_o !== 2'd2) begin
            err_cnt++; $display("FAIL rl_second got q=%h own=%0d exp q=b2 own=2", q_o, owner_o);
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_ni  = 1'b0;
        req_i   = '0;
        lock_i  = '0;
        wdata_i = '0;
        test_reset();
        test_round_robin();
        test_wrap();
        test_lock_release();
        test_timeout();
        test_final_cycle_write();
        test_reset_in_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
